samples_buffer: RTL and testbench

- Capture buffer feeding the accelerator's samples port.
- Packs a stream of 32-bit samples into 256-bit words and stores them in an on-chip RAM of DEPTH words.
- Exposes the RAM through a pipelined Wishbone B4 slave that supports classic cycles and incrementing bursts (linear and wrapped), which the accelerator uses to fetch sample words.
- Capture is linear: it stops when the RAM is full and rearms on clear_i.

---
 rtl/samples_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_samples_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/samples_buffer.sv
// Capture buffer: packs 32-bit samples into wide RAM words and serves them over a
// pipelined Wishbone B4 slave with classic and incrementing (linear/wrapped) bursts.
module samples_buffer #(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SAMPLE_WIDTH = 32,
    parameter int unsigned DEPTH        = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      samples_cyc_i,
    input  logic                      samples_stb_i,
    input  logic                      samples_we_i,
    output logic                      samples_ack_o,
    input  logic [ADDR_WIDTH-1:0]     samples_addr_i,
    input  logic [DATA_WIDTH-1:0]     samples_mosi_i,
    output logic [DATA_WIDTH-1:0]     samples_miso_o,
    input  logic [2:0]                samples_cti_i,
    input  logic [1:0]                samples_bte_i,
    input  logic                      clear_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [SAMPLE_WIDTH-1:0]   in_data_i,
    output logic [$clog2(DEPTH):0]    word_count_o,
    output logic                      full_o
);

    localparam int unsigned LANES  = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } wb_state_e;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ---------------- Packer ----------------
    logic [LANE_W-1:0]     r_lane;
    logic [DATA_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ready;

    logic                  w_accept;
    logic                  w_last_lane;
    logic                  w_pk_we;
    logic [CNT_W-1:0]      w_count_inc;
    logic [DATA_WIDTH-1:0] w_pk_word;

    // A sample offered alongside clear_i is dropped.
    assign w_accept    = in_valid_i & r_ready & ~clear_i;
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
    assign w_pk_we     = w_accept & w_last_lane;
    assign w_count_inc = r_count + CNT_W'(1);

    always_comb begin
        w_pk_word = r_word;
        for (int i = 0; i < LANES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_pk_word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane   <= '0;
            r_word   <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else if (clear_i) begin
            r_lane   <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else if (w_accept) begin
            r_word <= w_pk_word;
            if (w_last_lane) begin
                r_lane   <= '0;
                r_wr_ptr <= r_wr_ptr + IDX_W'(1);
                r_count  <= w_count_inc;
                r_ready  <= (w_count_inc != FULL_CNT);
            end else begin
                r_lane <= r_lane + LANE_W'(1);
            end
        end
    end

    assign in_ready_o   = r_ready;
    assign word_count_o = r_count;
    assign full_o       = (r_count == FULL_CNT);

    // ---------------- Wishbone slave ----------------
    wb_state_e             r_state;
    wb_state_e             w_state_next;
    logic                  r_ack;
    logic                  w_ack_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_access;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_miso;
    logic                  w_req;
    logic [IDX_W-1:0]      w_addr_idx;
    logic                  w_wb_we;
    logic                  w_unused_addr;

    assign w_req      = samples_cyc_i & samples_stb_i;
    assign w_addr_idx = samples_addr_i[OFF_W +: IDX_W];
    assign w_unused_addr = ^{samples_addr_i[ADDR_WIDTH-1:OFF_W+IDX_W], samples_addr_i[OFF_W-1:0]};

    // Wrapped bursts increment only the low bits selected by bte.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0]       bte);
        logic [IDX_W-1:0] mask;
        logic [IDX_W-1:0] inc;
        inc = idx + IDX_W'(1);
        case (bte)
            2'b01:   mask = IDX_W'(3);
            2'b10:   mask = IDX_W'(7);
            2'b11:   mask = IDX_W'(15);
            default: mask = '1;
        endcase
        return (idx & ~mask) | (inc & mask);
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_ack_next   = 1'b0;
        w_access     = 1'b0;
        w_idx_next   = r_idx;
        case (r_state)
            StIdle: begin
                // An ack cycle is always followed by an ack-low cycle in IDLE.
                if (w_req && !r_ack) begin
                    w_access   = 1'b1;
                    w_ack_next = 1'b1;
                    w_idx_next = w_addr_idx;
                    if (samples_cti_i == 3'b010) begin
                        w_state_next = StActive;
                    end
                end
            end
            StActive: begin
                if (!samples_cyc_i) begin
                    w_state_next = StIdle;
                end else if (samples_stb_i) begin
                    w_access   = 1'b1;
                    w_ack_next = 1'b1;
                    w_idx_next = next_idx(r_idx, samples_bte_i);
                    if (samples_cti_i != 3'b010) begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_miso  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            r_idx   <= w_idx_next;
            if (w_access) begin
                r_we    <= samples_we_i;
                r_wdata <= samples_mosi_i;
                r_miso  <= r_mem[w_idx_next];
            end
        end
    end

    // Write lands at the end of its ack cycle unless cyc was withdrawn; packer wins collisions.
    assign w_wb_we = r_ack & r_we & samples_cyc_i & ~(w_pk_we && (r_wr_ptr == r_idx));

    always_ff @(posedge clk) begin
        if (w_wb_we) begin
            r_mem[r_idx] <= r_wdata;
        end
        if (w_pk_we) begin
            r_mem[r_wr_ptr] <= w_pk_word;
        end
    end

    assign samples_ack_o  = r_ack;
    assign samples_miso_o = r_miso;

endmodule

// File: tb/tb_samples_buffer.sv
// Directed self-checking bench for samples_buffer: packing, fill/clear, classic and
// burst Wishbone accesses, write collision and asynchronous reset.
module tb_samples_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic         we = 1'b0;
    logic         ack;
    logic [31:0]  addr = '0;
    logic [255:0] mosi = '0;
    logic [255:0] miso;
    logic [2:0]   cti = '0;
    logic [1:0]   bte = '0;
    logic         clear = 1'b0;
    logic         valid = 1'b0;
    logic         ready;
    logic [31:0]  data = '0;
    logic [6:0]   count;
    logic         full;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] PAT  = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT2 = {8{32'h0BADF00D}};

    samples_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .samples_cyc_i  (cyc),
        .samples_stb_i  (stb),
        .samples_we_i   (we),
        .samples_ack_o  (ack),
        .samples_addr_i (addr),
        .samples_mosi_i (mosi),
        .samples_miso_o (miso),
        .samples_cti_i  (cti),
        .samples_bte_i  (bte),
        .clear_i        (clear),
        .in_valid_i     (valid),
        .in_ready_o     (ready),
        .in_data_i      (data),
        .word_count_o   (count),
        .full_o         (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_word(input int base);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) w[j*32 +: 32] = 32'(base + j);
        return w;
    endfunction

    task automatic feed(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            data  = 32'(base + i);
            tick();
        end
        valid = 1'b0;
    endtask

    task automatic classic_read(input string tag, input int idx, input logic [255:0] exp);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000; addr = 32'(idx * 32);
        tick();
        check({tag, " ack"}, 256'(ack), 256'(1));
        check({tag, " data"}, miso, exp);
        cyc = 1'b0; stb = 1'b0;
        tick();
        check({tag, " ack low"}, 256'(ack), 256'(0));
    endtask

    // idxs holds one expected word index per byte, first beat in the low byte.
    task automatic burst_read(input string tag, input int start, input logic [1:0] b,
                              input int n, input logic [63:0] idxs);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = b; addr = 32'(start * 32);
        for (int k = 0; k < n; k++) begin
            cti = (k == n - 1) ? 3'b111 : 3'b010;
            tick();
            check({tag, " ack"}, 256'(ack), 256'(1));
            check({tag, " data"}, miso, mk_word(8 * int'(idxs[k*8 +: 8])));
            addr = 32'hFFFF_F000;
        end
        cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
        tick();
        check({tag, " end ack"}, 256'(ack), 256'(0));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst ack", 256'(ack), 256'(0));
        check("rst miso", miso, 256'(0));
        check("rst ready", 256'(ready), 256'(1));
        check("rst count", 256'(count), 256'(0));
        check("rst full", 256'(full), 256'(0));
        @(negedge clk) rst_n = 1'b1;

        // Two words from 16 samples
        feed(0, 16);
        check("pack count", 256'(count), 256'(2));
        check("pack ready", 256'(ready), 256'(1));
        classic_read("rd0", 0, mk_word(0));
        classic_read("rd1", 1, mk_word(8));

        // Back-to-back classic write then read at index 5
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b000; addr = 32'h0A0; mosi = PAT;
        tick();
        check("wr ack", 256'(ack), 256'(1));
        we = 1'b0;
        tick();
        check("wr gap ack", 256'(ack), 256'(0));
        tick();
        check("rdback ack", 256'(ack), 256'(1));
        check("rdback data", miso, PAT);
        cyc = 1'b0; stb = 1'b0;
        tick();
        check("rdback ack low", 256'(ack), 256'(0));

        // Clear with a sample offered in the same cycle
        clear = 1'b1; valid = 1'b1; data = 32'hFFFF_FFFF;
        tick();
        clear = 1'b0; valid = 1'b0;
        check("clr count", 256'(count), 256'(0));
        check("clr ready", 256'(ready), 256'(1));

        // Fill all 64 words
        for (int i = 0; i < 512; i++) begin
            valid = 1'b1;
            data  = 32'(i);
            tick();
            if (i == 510) begin
                check("fill511 ready", 256'(ready), 256'(1));
                check("fill511 full", 256'(full), 256'(0));
                check("fill511 count", 256'(count), 256'(63));
            end
        end
        check("fill full", 256'(full), 256'(1));
        check("fill ready", 256'(ready), 256'(0));
        check("fill count", 256'(count), 256'(64));
        data = 32'd512;
        tick();
        valid = 1'b0;
        check("overflow count", 256'(count), 256'(64));
        check("overflow full", 256'(full), 256'(1));

        // Bursts over the filled RAM: word k = samples 8k..8k+7
        burst_read("lin", 63, 2'b00, 4, 64'({8'd2, 8'd1, 8'd0, 8'd63}));
        burst_read("wrap4", 6, 2'b01, 4, 64'({8'd5, 8'd4, 8'd7, 8'd6}));
        burst_read("wrap8", 13, 2'b10, 8,
                   {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd15, 8'd14, 8'd13});

        // stb drops mid-burst: index holds, burst resumes
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; addr = 32'(10 * 32);
        tick();
        check("pause ack0", 256'(ack), 256'(1));
        check("pause data0", miso, mk_word(80));
        stb = 1'b0;
        tick();
        check("pause ack low", 256'(ack), 256'(0));
        stb = 1'b1; cti = 3'b111;
        tick();
        check("resume ack", 256'(ack), 256'(1));
        check("resume data", miso, mk_word(88));
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        tick();
        check("resume end", 256'(ack), 256'(0));

        // cyc withdrawn during the ack cycle discards the write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'(20 * 32); mosi = PAT2;
        tick();
        check("abort ack", 256'(ack), 256'(1));
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("abort ack low", 256'(ack), 256'(0));
        classic_read("abort rd", 20, mk_word(160));

        // Collision: Wishbone write and packer completion on index 0 in the same cycle
        clear = 1'b1;
        tick();
        clear = 1'b0;
        feed(256, 7);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0; mosi = PAT;
        tick();
        check("coll ack", 256'(ack), 256'(1));
        stb = 1'b0; valid = 1'b1; data = 32'd263;
        tick();
        cyc = 1'b0; we = 1'b0; valid = 1'b0;
        check("coll count", 256'(count), 256'(1));
        classic_read("coll rd", 0, mk_word(256));

        // Asynchronous reset mid-burst with a partial word packed
        feed(768, 3);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; addr = 32'h0;
        tick();
        check("prerst ack", 256'(ack), 256'(1));
        rst_n = 1'b0;
        #1;
        check("async ack", 256'(ack), 256'(0));
        check("async count", 256'(count), 256'(0));
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("postrst count", 256'(count), 256'(0));
        check("postrst ready", 256'(ready), 256'(1));
        feed(512, 8);
        check("postrst word", 256'(count), 256'(1));
        classic_read("postrst rd", 0, mk_word(512));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
